// File: rtl/program_loader.sv
// program_loader
//
// Fills instruction memory from a byte stream before the core is released.
// The stream is a 32-bit little-endian word count followed by that many
// little-endian instruction words. Each assembled word is written with a
// single-cycle mem_we pulse; the core is held stalled while loading and stays
// stalled if the count does not fit in memory.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request to begin a load (honoured only when not loading)
//   rx_data    incoming byte
//   rx_valid   rx_data is valid
//   rx_ready   loader accepts a byte this cycle
//   mem_we     instruction memory word write enable (one cycle per word)
//   mem_addr   word index of the write (not a byte address)
//   mem_wdata  assembled instruction word
//   cpu_hold   stall/reset request to the core
//   busy       load in progress
//   done       last load completed successfully
//   error      last load rejected because the word count exceeded capacity

module program_loader #(
    parameter int MEMORY_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] CAP_WORDS = 32'(MEMORY_SIZE / 4);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  byte_cnt;
    logic [31:0] word_idx;
    logic [31:0] length;
    logic [31:0] word_buf;

    logic        take;
    logic        last_byte;
    logic        last_word;
    logic        start_ok;
    logic [31:0] len_next;
    logic [31:0] word_next;

    // All handshake-facing outputs come straight from the registered state,
    // so they never depend combinationally on rx_valid or start.
    assign rx_ready = (state == LEN) || (state == DATA);
    assign mem_we   = (state == WRITE);
    assign busy     = (state == LEN) || (state == DATA) || (state == WRITE);
    assign cpu_hold = busy || (state == ERROR);
    assign done     = (state == DONE);
    assign error    = (state == ERROR);

    assign take      = rx_valid && rx_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

    // Bytes arrive LSB first: shifting in from the top leaves byte 0 in 7:0
    // once all four have been taken.
    assign len_next  = {rx_data, length[31:8]};
    assign word_next = {rx_data, word_buf[31:8]};

    // word_idx never exceeds length-1, and length is capped well below 2^32,
    // so the increment cannot wrap.
    assign last_word = ((word_idx + 32'd1) == length);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                if (take && last_byte) begin
                    if (len_next == 32'd0) begin
                        state_nxt = DONE;
                    end else if (len_next > CAP_WORDS) begin
                        state_nxt = ERROR;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (take && last_byte) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = last_word ? DONE : DATA;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt  <= 2'd0;
            word_idx  <= 32'd0;
            length    <= 32'd0;
            word_buf  <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (start_ok) begin
            byte_cnt <= 2'd0;
            word_idx <= 32'd0;
            length   <= 32'd0;
        end else begin
            case (state)
                LEN: begin
                    if (take) begin
                        length   <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                DATA: begin
                    if (take) begin
                        word_buf <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Capture the write port on the final byte so it is
                        // stable for the WRITE cycle and held afterwards.
                        if (last_byte) begin
                            mem_addr  <= word_idx;
                            mem_wdata <= word_next;
                        end
                    end
                end
                WRITE: begin
                    if (!last_word) begin
                        word_idx <= word_idx + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int MEMORY_SIZE = 1024;
    localparam int CAP         = MEMORY_SIZE / 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    program_loader #(.MEMORY_SIZE(MEMORY_SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the load as "bytes received so far" plus a pending-write flag;
    // expected outputs follow from those counts.
    bit          m_active;
    bit          m_wpend;
    int          m_result;   // 0 none, 1 done, 2 error
    int          m_nb;
    logic [31:0] m_len;
    logic [31:0] m_waddr;
    logic [31:0] m_wdata;
    logic [7:0]  m_bytes[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_wpend  = 1'b0;
            m_result = 0;
            m_nb     = 0;
            m_len    = 32'd0;
            m_waddr  = 32'd0;
            m_wdata  = 32'd0;
            m_bytes.delete();
        end else if (m_wpend) begin
            m_wpend = 1'b0;
            if ((m_nb / 4 - 1) == int'(m_len)) begin
                m_active = 1'b0;
                m_result = 1;
            end
        end else if (m_active) begin
            if (rx_valid) begin
                m_bytes.push_back(rx_data);
                m_nb++;
                if (m_nb == 4) begin
                    m_len = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    if (m_len == 32'd0) begin
                        m_active = 1'b0;
                        m_result = 1;
                    end else if (m_len > 32'(CAP)) begin
                        m_active = 1'b0;
                        m_result = 2;
                    end
                end else if (m_nb % 4 == 0) begin
                    m_wpend = 1'b1;
                    m_waddr = 32'(m_nb / 4 - 2);
                    m_wdata = {m_bytes[m_nb-1], m_bytes[m_nb-2], m_bytes[m_nb-3], m_bytes[m_nb-4]};
                end
            end
        end else if (start) begin
            m_active = 1'b1;
            m_result = 0;
            m_nb     = 0;
            m_bytes.delete();
        end
    end

    // ---------------- per-cycle compare + memory capture ----------------
    logic [31:0] dm [0:CAP-1];
    int          we_cnt   = 0;
    int          consumed = 0;

    always @(negedge clk) begin
        chk("rx_ready",  32'(rx_ready), 32'(m_active && !m_wpend));
        chk("mem_we",    32'(mem_we),   32'(m_wpend));
        chk("busy",      32'(busy),     32'(m_active));
        chk("cpu_hold",  32'(cpu_hold), 32'(m_active || (m_result == 2)));
        chk("done",      32'(done),     32'(!m_active && (m_result == 1)));
        chk("error",     32'(error),    32'(!m_active && (m_result == 2)));
        chk("mem_addr",  mem_addr,      m_waddr);
        chk("mem_wdata", mem_wdata,     m_wdata);
        if (mem_we) begin
            dm[mem_addr[7:0]] = mem_wdata;
            we_cnt++;
        end
    end

    always @(posedge clk) begin
        if (!reset && rx_valid && rx_ready) consumed++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: rx_ready stayed 0 for byte 0x%02h", b);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int c0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word load
        pulse_start();
        chk("start_busy",     32'(busy),     32'd1);
        chk("start_rx_ready", 32'(rx_ready), 32'd1);
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        @(negedge clk);
        chk("t1_done",     32'(done),     32'd1);
        chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("t1_busy",     32'(busy),     32'd0);
        chk("t1_mem0",     dm[0],         32'h0000_0013);
        chk("t1_mem1",     dm[1],         32'h0010_0093);
        chk("t1_we_cnt",   32'(we_cnt),   32'd2);

        // Zero length
        w0 = we_cnt;
        pulse_start();
        send_word(32'd0, 0);
        chk("t2_done", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        chk("t2_no_we", 32'(we_cnt - w0), 32'd0);

        // Overflow: 257 words
        w0 = we_cnt;
        pulse_start();
        send_word(32'h0000_0101, 0);
        chk("t3_error",    32'(error),    32'd1);
        chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t3_rx_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_no_we", 32'(we_cnt - w0), 32'd0);
        pulse_start();
        chk("t3_error_clr", 32'(error), 32'd0);
        send_word(32'd1, 0);
        send_word(32'hCAFE_F00D, 0);
        @(negedge clk);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_mem0", dm[0],     32'hCAFE_F00D);

        // Backpressure and gaps, rx_valid held through WRITE
        w0 = we_cnt;
        c0 = consumed;
        pulse_start();
        send_word(32'd1, 4);
        send_word(32'h1234_5678, 4);
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("t4_consumed", 32'(consumed - c0), 32'd8);
        chk("t4_writes",   32'(we_cnt - w0),   32'd1);
        chk("t4_mem0",     dm[0],              32'h1234_5678);
        chk("t4_done",     32'(done),          32'd1);

        // Reset mid-word of a 3-word load
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'hA0A1_A2A3, 0);
        send_byte(8'hB3, 0);
        send_byte(8'hB2, 0);
        #2 reset = 1'b1;
        #1;
        chk("t5_rx_ready",  32'(rx_ready), 32'd0);
        chk("t5_mem_we",    32'(mem_we),   32'd0);
        chk("t5_mem_addr",  mem_addr,      32'd0);
        chk("t5_mem_wdata", mem_wdata,     32'd0);
        chk("t5_cpu_hold",  32'(cpu_hold), 32'd0);
        chk("t5_busy",      32'(busy),     32'd0);
        chk("t5_done",      32'(done),     32'd0);
        chk("t5_error",     32'(error),    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        w0 = we_cnt;
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'hA0A1_A2A3, 0);
        send_word(32'hB0B1_B2B3, 0);
        send_word(32'hC0C1_C2C3, 0);
        @(negedge clk);
        chk("t5_mem0",   dm[0],             32'hA0A1_A2A3);
        chk("t5_mem1",   dm[1],             32'hB0B1_B2B3);
        chk("t5_mem2",   dm[2],             32'hC0C1_C2C3);
        chk("t5_writes", 32'(we_cnt - w0),  32'd3);
        chk("t5_done2",  32'(done),         32'd1);

        // Start while busy, then reload from DONE
        pulse_start();
        send_word(32'd1, 0);
        send_byte(8'h33, 0);
        pulse_start();
        chk("t6_still_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("t6_done1", 32'(done), 32'd1);
        chk("t6_mem0a", dm[0],     32'h0000_0033);
        pulse_start();
        chk("t6_done_clr", 32'(done), 32'd0);
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("t6_mem0b", dm[0],     32'hDEAD_BEEF);
        chk("t6_done2", 32'(done), 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that fills the instruction memory before the core runs. It accepts bytes over a valid/ready handshake, reads a 32-bit little-endian word count, assembles little-endian instruction words, and issues one single-cycle word write per instruction. It holds the core stalled for the duration of the load, then releases it. It sits between the host-side byte source (UART receiver or testbench) and the instruction memory write port.

## Interface

- MEMORY_SIZE, 1024: instruction memory size in bytes; capacity is MEMORY_SIZE/4 words.

- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle request to begin a load; sampled in IDLE, DONE, ERROR only
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  instruction memory word write enable, one cycle per word
- mem_addr  output  32  word index, not byte address
- mem_wdata  output  32  assembled instruction word
- cpu_hold  output  1  stall/reset request to the core
- busy  output  1  load in progress
- done  output  1  last load completed successfully
- error  output  1  last load rejected (length overflow)

## Operation

- Byte transfer occurs on a rising edge where rx_valid && rx_ready. No other edge consumes a byte.
- rx_ready is decoded from registered state: 1 in LEN and DATA, 0 elsewhere.
- States: IDLE, LEN, DATA, WRITE, DONE, ERROR.
- IDLE: outputs inactive. start moves to LEN.
- Entry to LEN from any state clears byte counter, word index, length register, done, and error.
- LEN: four accepted bytes form length, LSB first.
  - On the 4th byte, length==0 goes to DONE.
  - length > MEMORY_SIZE/4 goes to ERROR.
  - Otherwise go to DATA.
- DATA: accepted bytes are shifted into the word, LSB first (byte 0 lands in bits 7:0). A 2-bit byte counter wraps 3→0. The 4th byte goes to WRITE.
- WRITE: for exactly one cycle, mem_we=1, mem_addr=word index, mem_wdata=assembled word. Next state:
  - word index+1 == length goes to DONE.
  - Otherwise word index increments and the state returns to DATA.
- DONE: done=1 and cpu_hold=0. start goes to LEN (reload).
- ERROR: error=1 and cpu_hold=1 (core stays stalled). start goes to LEN.
- start is ignored in LEN, DATA, and WRITE.
- busy=1 in LEN, DATA, and WRITE.
- cpu_hold=1 in LEN, DATA, WRITE, and ERROR.
- mem_addr and mem_wdata hold their last values outside WRITE. The memory must only sample them when mem_we=1.
- Width rules:
  - length is 32 bits; the comparison is unsigned.
  - word index is 32 bits and never exceeds length-1.

## Timing

- Reset values: state IDLE, rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 0, busy 0, done 0, error 0.
- Reset is asynchronous and takes effect immediately in any state:
  - A partial word is discarded.
  - Words already written stay in memory.
  - done and error are cleared.
- The 4th byte of a word is accepted at edge N. mem_we is high in cycle N+1. rx_ready returns to 1 in cycle N+2.
- Minimum 5 cycles per word at full rate; rx_ready drops for one cycle per word.
- DONE (done=1, cpu_hold=0) starts the cycle after the final WRITE cycle.
- ERROR or zero-length DONE starts the cycle after the 4th length byte.
- start at edge N in IDLE/DONE/ERROR gives busy=1 and rx_ready=1 from cycle N+1.
- rx_valid gaps of any length stall the load without side effects. rx_data is don't-care when rx_valid=0.

## Test plan

- **Two-word load:** start, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00.
  - mem_we pulse at addr 0 with 0x00000013.
  - mem_we pulse at addr 1 with 0x00100093.
  - Then done=1, cpu_hold=0, busy=0.
- **Zero length:** start, then 00 00 00 00.
  - No mem_we pulse.
  - done=1 the cycle after the 4th byte.
- **Overflow (MEMORY_SIZE=1024):** length bytes 01 01 00 00 (257 words).
  - error=1, cpu_hold=1, rx_ready=0, no mem_we.
  - A second start then a valid 1-word load recovers to done=1.
- **Backpressure and gaps:** 1-word load with rx_valid toggled randomly, plus rx_valid held high during the WRITE cycle.
  - Exactly 8 bytes consumed.
  - Single write of the correct word.
  - No byte lost or duplicated.
- **Reset mid-word:** assert reset after 2 payload bytes of word 1 of a 3-word load.
  - All outputs immediately take their reset values.
  - A fresh start plus full 3-word stream writes addrs 0..2 correctly.
- **Start while busy, then reload:** pulse start during DATA; it is ignored and the load completes normally. Then start from DONE with a 1-word load.
  - done clears on entry to LEN.
  - addr 0 is rewritten.
  - done=1 again.
